icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache plus refill controller that answers fetch-stage requests: the responder side of the PC-to-instruction interface. On a hit it returns the 16-bit instruction in the same cycle. On a miss it raises `stall_f` to freeze the PC register, streams the 8-word block in from the multicycle memory, and then serves the request. It sits between the fetch stage and the shared memory port.

## Interface
- `INDEX_BITS`, default 6: number of index bits; cache holds 2^INDEX_BITS blocks of 8 words (16 bytes).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_addr`  in  16  byte address of the requested instruction (current PC); bit 0 ignored.
- `fetch_req`  in  1  fetch wants an instruction this cycle.
- `instr_out`  out  16  instruction word; 16'h0000 whenever `instr_valid`=0.
- `instr_valid`  out  1  `instr_out` holds the word at `fetch_addr` this cycle.
- `stall_f`  out  1  miss in progress; fetch must hold its PC.
- `mem_addr`  out  16  byte address of the word being read from memory.
- `mem_rd`  out  1  memory read request, one word per cycle.
- `mem_data`  in  16  memory read data.
- `mem_data_valid`  in  1  `mem_data` carries the next word of the current block.

## Operation
- Address split: word offset = `fetch_addr[3:1]`, index = `fetch_addr[3+INDEX_BITS:4]`, tag = remaining upper bits (6 bits at default).
- Storage: per block a valid bit, a tag and 8×16 data words. Lookup is combinational.
- Hit = `fetch_req` & FSM in IDLE & valid[index] & tag match. On hit: `instr_valid`=1, `instr_out`=data[index][offset], `stall_f`=0.
- Miss = `fetch_req` & IDLE & no hit. On miss: `stall_f`=1 combinationally in the same cycle, block base `{fetch_addr[15:4],4'h0}` latched, FSM goes to FILL.
- FSM states:
  - IDLE: -> FILL on miss.
  - FILL: issue counter `rq` runs 0..7. `mem_rd`=1 and `mem_addr`=base+2·rq while rq<8; `rq` increments each cycle. Receive counter `rv` runs 0..7; each cycle with `mem_data_valid`=1, `mem_data` is written to data[index][rv] and `rv` increments. On the 8th word: valid[index]=1, tag written, -> DONE.
  - DONE: one cycle with `stall_f`=1 and `instr_valid`=0; -> IDLE, where the held PC now hits.
- During FILL/DONE: `stall_f`=1, `instr_valid`=0, and changes on `fetch_addr` or `fetch_req` are ignored because the latched base is used.
- valid[index] is cleared on entry to FILL, so a partially refilled block is never seen as a hit.
- `mem_data_valid` is ignored in IDLE and DONE, and after `rv` reaches 8.
- `fetch_req`=0 in IDLE: no lookup side effects; `instr_valid`=0, `stall_f`=0.
- No writes from the pipeline. Memory responses return in request order.

## Timing
- Reset: FSM=IDLE, all valid bits 0, `rq`=`rv`=0. Outputs `mem_rd`=0, `mem_addr`=0, `stall_f`=0, `instr_valid`=0, `instr_out`=0. Tags and data are unreset.
- `rst` during FILL/DONE aborts the refill. Next cycle: IDLE, `mem_rd`=0, `stall_f`=0; the block stays invalid.
- Hit latency: 0 cycles (same cycle).
- Miss cycle T: `stall_f` high. `mem_rd` high T+1..T+8. With 4-cycle memory, data arrives T+5..T+12. DONE at T+13, hit at T+14; `stall_f` high T..T+13 (14 cycles).
- The cache does not hard-code memory latency; completion is purely by counting 8 `mem_data_valid` pulses.
- `mem_addr` changes only on clock edges.

## Test plan
- Reset, `fetch_req`=1, `fetch_addr`=0x0000, memory returns 0x1000+k for word k at 4-cycle latency -> `mem_rd` T+1..T+8 with addresses 0x0000,0x0002..0x000E; `stall_f` high 14 cycles; at T+14 `instr_valid`=1, `instr_out`=0x1000.
- After that fill, `fetch_addr`=0x000A -> same-cycle `instr_out`=0x1005, `instr_valid`=1, `mem_rd` never asserted.
- Conflict: fetch 0x0400 (same index, tag 1) -> full refill from 0x0400..0x040E. A later fetch of 0x0000 -> miss again.
- Assert `rst` for one cycle at T+6 of a fill -> `mem_rd`=0 and `stall_f`=0 the next cycle. Refetching 0x0000 misses with a full 8-word refill.
- Pulse `mem_data_valid` with 0xDEAD in IDLE, then fetch a cached address -> returned data unchanged and no state change.
- Toggle `fetch_addr` to 0x0040 mid-fill of 0x0000 -> refill addresses stay 0x0000..0x000E. After DONE, 0x0040 misses and a new fill starts.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with an 8-word block refill FSM
module icache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_addr,
  input  logic        fetch_req,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        stall_f,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid
);
  localparam int NB = 1 << INDEX_BITS;
  localparam int TW = 12 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t                state;
  logic [NB-1:0]         valid;
  logic [TW-1:0]         tags [NB];
  logic [15:0]           data [NB][8];
  logic [11:0]           base;
  logic [3:0]            rq, rv;
  logic [INDEX_BITS-1:0] idx, fidx;
  logic [TW-1:0]         ftag;
  logic [2:0]            off;
  logic                  hit, miss, wr;
  logic                  unused_a0;
  assign unused_a0   = fetch_addr[0];
  assign off         = fetch_addr[3:1];
  assign fidx        = fetch_addr[3+INDEX_BITS:4];
  assign ftag        = fetch_addr[15:4+INDEX_BITS];
  assign idx         = base[INDEX_BITS-1:0];
  assign hit         = fetch_req && state == IDLE && valid[fidx] && tags[fidx] == ftag;
  assign miss        = fetch_req && state == IDLE && !hit;
  assign instr_valid = hit;
  assign instr_out   = hit ? data[fidx][off] : 16'h0000;
  assign stall_f     = miss || state != IDLE;
  assign wr          = state == FILL && mem_data_valid && !rv[3];
  always_ff @(posedge clk) begin
    if (wr) data[idx][rv[2:0]] <= mem_data;
    if (wr && rv == 4'd7) tags[idx] <= base[11:INDEX_BITS];
  end
  // rq holds the index of the next word to request; word 0 is issued on the miss edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      base     <= '0;
      rq       <= '0;
      rv       <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          state       <= FILL;
          base        <= fetch_addr[15:4];
          valid[fidx] <= 1'b0;
          rq          <= 4'd1;
          rv          <= '0;
          mem_rd      <= 1'b1;
          mem_addr    <= {fetch_addr[15:4], 4'h0};
        end
        FILL: begin
          mem_rd   <= !rq[3];
          mem_addr <= rq[3] ? 16'h0000 : {base, rq[2:0], 1'b0};
          if (!rq[3]) rq <= rq + 4'd1;
          if (wr) rv <= rv + 4'd1;
          if (wr && rv == 4'd7) begin
            valid[idx] <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state    <= IDLE;
          mem_rd   <= 1'b0;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed and random fetches against a transaction-level cache model
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst, fetch_req, mem_data_valid, instr_valid, stall_f, mem_rd;
  logic [15:0] fetch_addr, mem_data, instr_out, mem_addr;
  int          n_cmp = 0, n_err = 0, cyc = 0, lat = 4;
  logic [15:0] mem [32768];
  logic        m_valid [64];
  logic [5:0]  m_tag [64];
  logic [15:0] adr_q [$];
  int          due_q [$];
  logic [15:0] seen [$];

  icache_ctrl dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_req(fetch_req),
    .instr_out(instr_out), .instr_valid(instr_valid), .stall_f(stall_f),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  // in-order memory with a fixed latency of lat cycles from request to data
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      mem_data_valid = 1'b1;
      mem_data = mem[adr_q[0][15:1]];
      void'(due_q.pop_front());
      void'(adr_q.pop_front());
    end else begin
      mem_data_valid = 1'b0;
      mem_data = 16'h0000;
    end
    if (mem_rd === 1'b1) begin
      adr_q.push_back(mem_addr);
      due_q.push_back(cyc + lat);
      seen.push_back(mem_addr);
    end
    #1;
  endtask

  task automatic chk_reads(input string nm, input logic [15:0] base);
    chk({nm, "_nreads"}, 16'(seen.size()), 16'd8);
    for (int k = 0; k < 8; k++)
      chk({nm, "_rdaddr"}, (k < seen.size()) ? seen[k] : 16'hxxxx, base + 16'(2 * k));
  endtask

  task automatic fetch(input logic [15:0] a);
    logic       hit_e;
    logic [5:0] ix;
    int         n, st;
    ix = a[9:4];
    hit_e = m_valid[ix] && m_tag[ix] == a[15:10];
    fetch_req = 1'b1;
    fetch_addr = a;
    seen.delete();
    #1;
    chk("hit", 16'(instr_valid), 16'(hit_e));
    chk("stall_first", 16'(stall_f), 16'(!hit_e));
    if (!hit_e) begin
      n = 0;
      st = 0;
      while (instr_valid !== 1'b1 && n < 100) begin
        st += int'(stall_f);
        tick();
        n++;
      end
      chk("fill_cycles", 16'(n), 16'(10 + lat));
      chk("stall_cycles", 16'(st), 16'(10 + lat));
      chk("stall_end", 16'(stall_f), 16'd0);
      chk_reads("fill", {a[15:4], 4'h0});
      m_valid[ix] = 1'b1;
      m_tag[ix] = a[15:10];
    end
    chk("instr", instr_out, mem[a[15:1]]);
    seen.delete();
    tick();
    if (hit_e) chk("hit_no_rd", 16'(seen.size()), 16'd0);
    fetch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0;
    fetch_addr = '0;
    mem_data_valid = 1'b0;
    mem_data = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 8; k++) mem[k] = 16'h1000 + 16'(k);
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_rd", 16'(mem_rd), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_stall", 16'(stall_f), 16'd0);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_instr", instr_out, 16'h0000);
    fetch(16'h0000);
    fetch(16'h000A);
    chk("hit_word5", mem[5], 16'h1005);
    fetch_addr = 16'h000A;
    #1;
    chk("noreq_valid", 16'(instr_valid), 16'd0);
    chk("noreq_stall", 16'(stall_f), 16'd0);
    chk("noreq_instr", instr_out, 16'h0000);
    fetch(16'h0400);
    fetch(16'h0000);
    // abort a refill with reset at T+6
    fetch_req = 1'b1;
    fetch_addr = 16'h0400;
    #1;
    chk("abort_miss", 16'(stall_f), 16'd1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch_req = 1'b0;
    adr_q.delete();
    due_q.delete();
    mem_data_valid = 1'b0;
    #1;
    chk("abort_mem_rd", 16'(mem_rd), 16'd0);
    chk("abort_stall", 16'(stall_f), 16'd0);
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    fetch(16'h0000);
    // stray memory data in IDLE must not disturb cached contents
    @(posedge clk);
    #1;
    mem_data_valid = 1'b1;
    mem_data = 16'hDEAD;
    #1;
    chk("stray_stall", 16'(stall_f), 16'd0);
    @(posedge clk);
    #1;
    mem_data_valid = 1'b0;
    mem_data = 16'h0000;
    fetch(16'h0006);
    fetch(16'h0000);
    // fetch_addr moves mid-fill; the refill must follow the latched block
    fetch_req = 1'b1;
    fetch_addr = 16'h0800;
    seen.delete();
    #1;
    chk("toggle_miss", 16'(stall_f), 16'd1);
    repeat (3) tick();
    fetch_addr = 16'h0040;
    repeat (11) tick();
    chk("toggle_new_miss_valid", 16'(instr_valid), 16'd0);
    chk("toggle_new_miss_stall", 16'(stall_f), 16'd1);
    chk_reads("toggle", 16'h0800);
    m_valid[0] = 1'b1;
    m_tag[0] = 6'd2;
    fetch(16'h0040);
    fetch(16'h0800);
    for (int r = 0; r < 60; r++) begin
      lat = int'($urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) begin
        fetch_addr = 16'($urandom);
        #1;
        chk("rand_idle_valid", 16'(instr_valid), 16'd0);
        chk("rand_idle_stall", 16'(stall_f), 16'd0);
        tick();
      end
      fetch(16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
